// File: rtl/router_output_ctrl_pkg.sv
// Shared NoC definitions: packet width, header field positions and VC encoding.
package router_output_ctrl_pkg;

   localparam int DATA_W  = 64;
   localparam int VC_BIT  = 63;
   localparam int DIR_BIT = 62;
   localparam int HOP_HI  = 55;
   localparam int HOP_LO  = 48;

   // Virtual channel selected by the network phase
   typedef enum logic {
      VC_EVEN = 1'b0,
      VC_ODD  = 1'b1
   } vc_e;

endpackage

// File: rtl/router_output_ctrl_if.sv
// Arbiter-write and downstream-link signals of one router output port.
interface router_output_ctrl_if #(
   parameter int DATA_W = router_output_ctrl_pkg::DATA_W
);
   logic              even_wr_en;
   logic [DATA_W-1:0] even_wr_data;
   logic              odd_wr_en;
   logic [DATA_W-1:0] odd_wr_data;
   logic              even_empty;
   logic              odd_empty;
   logic              out_send;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;

   // Arbiters and the downstream buffer side
   modport master (
      output even_wr_en, even_wr_data, odd_wr_en, odd_wr_data, out_ready,
      input  even_empty, odd_empty, out_send, out_data
   );

   // Output controller side
   modport slave (
      input  even_wr_en, even_wr_data, odd_wr_en, odd_wr_data, out_ready,
      output even_empty, odd_empty, out_send, out_data
   );
endinterface

// File: rtl/router_output_ctrl_vc_slot.sv
// One-entry packet buffer for a single virtual channel.
module vc_slot
   import router_output_ctrl_pkg::*;
#(
   parameter int SLOT_W = DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [SLOT_W-1:0] wr_data,
   input  logic              clear,
   output logic [SLOT_W-1:0] data,
   output logic              full,
   output logic              empty,
   output logic              reject
);

   // Empty and reject depend only on the registered flag, never on same-cycle traffic
   assign empty  = ~full;
   assign reject = wr_en & full;

   // Load on write into an empty slot; a clear only happens while full, so a write that
   // coincides with a clear is rejected and the old packet leaves intact
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data <= '0;
         full <= 1'b0;
      end else if (wr_en && !full) begin
         data <= wr_data;
         full <= 1'b1;
      end else if (clear) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/router_output_ctrl.sv
// Router output port: two VC slots, phase-selected link send, sent counter, overflow flag.
module router_output_ctrl #(
   parameter int DATA_W = router_output_ctrl_pkg::DATA_W,
   parameter int CNT_W  = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               polarity,
   router_output_ctrl_if.slave bus,
   output logic [CNT_W-1:0]   sent_count,
   output logic               overflow_err
);
   import router_output_ctrl_pkg::*;

   logic [DATA_W-1:0] even_data;
   logic [DATA_W-1:0] odd_data;
   logic              even_full;
   logic              odd_full;
   logic              even_reject;
   logic              odd_reject;
   logic              even_clear;
   logic              odd_clear;
   vc_e               link_vc;
   logic              link_full;
   logic [DATA_W-1:0] link_data;
   logic              send_now;
   logic              out_send_r;
   logic [DATA_W-1:0] out_data_r;

   // Counter increment that sticks at all-ones instead of wrapping
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   vc_slot #(.SLOT_W(DATA_W)) u_even (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (bus.even_wr_en),
      .wr_data (bus.even_wr_data),
      .clear   (even_clear),
      .data    (even_data),
      .full    (even_full),
      .empty   (bus.even_empty),
      .reject  (even_reject)
   );

   vc_slot #(.SLOT_W(DATA_W)) u_odd (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (bus.odd_wr_en),
      .wr_data (bus.odd_wr_data),
      .clear   (odd_clear),
      .data    (odd_data),
      .full    (odd_full),
      .empty   (bus.odd_empty),
      .reject  (odd_reject)
   );

   // Only the slot matching the current phase may drive the link
   assign link_vc    = vc_e'(polarity);
   assign link_full  = (link_vc == VC_ODD) ? odd_full : even_full;
   assign link_data  = (link_vc == VC_ODD) ? odd_data : even_data;
   assign send_now   = link_full & bus.out_ready;
   assign even_clear = send_now & (link_vc == VC_EVEN);
   assign odd_clear  = send_now & (link_vc == VC_ODD);

   // Registered link outputs, saturating sent counter and sticky overflow flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_send_r   <= 1'b0;
         out_data_r   <= '0;
         sent_count   <= '0;
         overflow_err <= 1'b0;
      end else begin
         out_send_r <= send_now;
         if (send_now) begin
            out_data_r <= link_data;
            sent_count <= sat_inc(sent_count);
         end
         overflow_err <= overflow_err | even_reject | odd_reject;
      end
   end

   assign bus.out_send = out_send_r;
   assign bus.out_data = out_data_r;

endmodule
